// File: rtl/subneg_pkg.sv
// subneg_pkg: shared types and default widths for the SUBNEG execution unit.
//   exec_state_t : IDLE (accepting), BUSY (computing), DONE (holding result)
//   DATA_W, PC_W : default operand and program-counter widths
// Optional feature macro used across the slice: SUBNEG_OVF_EN (adds ovf output,
// makes neg the true sign of b - a).
package subneg_pkg;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exec_state_t;
endpackage

// File: rtl/subneg_if.sv
// subneg_if: operand/result handshake bundle for subneg_exec.
//   in channel : in_valid/in_ready, a, b, pc, target
//   out channel: out_valid/out_ready, result, neg, next_pc (+ ovf with SUBNEG_OVF_EN)
//   master : operand fetch / writeback side; slave : the execution unit.
interface subneg_if #(
  parameter int WIDTH = 8,
  parameter int PC_W  = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             neg;
  logic [PC_W-1:0]  next_pc;
`ifdef SUBNEG_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, pc, target, out_ready,
                  input  in_ready, out_valid, result, neg, next_pc, ovf);
  modport slave  (input  in_valid, a, b, pc, target, out_ready,
                  output in_ready, out_valid, result, neg, next_pc, ovf);
`else
  modport master (output in_valid, a, b, pc, target, out_ready,
                  input  in_ready, out_valid, result, neg, next_pc);
  modport slave  (input  in_valid, a, b, pc, target, out_ready,
                  output in_ready, out_valid, result, neg, next_pc);
`endif
endinterface

// File: rtl/subneg_sub.sv
// subneg_sub: combinational signed subtractor, diff = b - a (wrapped).
//   a, b : signed operands (two's complement)
//   diff : wrapped difference
//   sign : branch sign; with SUBNEG_OVF_EN the true sign of the
//          mathematical difference, otherwise diff's msb
//   ovf  : signed overflow (only with SUBNEG_OVF_EN)
module subneg_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
`ifdef SUBNEG_OVF_EN
  output logic             ovf,
`endif
  output logic             sign
);
  assign diff = b - a;

`ifdef SUBNEG_OVF_EN
  // Overflow only possible when operand signs differ; then the wrapped
  // result's sign disagrees with the minuend's.
  assign ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
  assign sign = diff[WIDTH-1] ^ ovf;
`else
  assign sign = diff[WIDTH-1];
`endif
endmodule

// File: rtl/subneg_exec.sv
// subneg_exec: subtract-and-branch-if-negative execution unit.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : subneg_if.slave -- operands a/b, pc, target in;
//                result = b - a, neg, next_pc = neg ? target : pc+1 out
//                (ovf out as well when SUBNEG_OVF_EN is defined)
// One transaction at a time: IDLE accepts, BUSY computes, DONE holds the
// registered result until out_ready.
module subneg_exec
  import subneg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int PC_W  = subneg_pkg::PC_W
) (
  input  logic     clk,
  input  logic     rst_n,
  subneg_if.slave  bus
);
  exec_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PC_W-1:0]  pc_q, pc_d, tgt_q, tgt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic [PC_W-1:0]  next_pc_q, next_pc_d;
  logic [WIDTH-1:0] diff;
  logic             sign;
`ifdef SUBNEG_OVF_EN
  logic             sub_ovf;
  logic             ovf_q, ovf_d;
`endif

  subneg_sub #(.WIDTH(WIDTH)) u_sub (
    .a    (a_q),
    .b    (b_q),
    .diff (diff),
`ifdef SUBNEG_OVF_EN
    .ovf  (sub_ovf),
`endif
    .sign (sign)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    result_d  = result_q;
    neg_d     = neg_q;
    next_pc_d = next_pc_q;
`ifdef SUBNEG_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        pc_d    = bus.pc;
        tgt_d   = bus.target;
        state_d = BUSY;
      end
      BUSY: begin
        result_d  = diff;
        neg_d     = sign;
        next_pc_d = sign ? tgt_q : pc_q + 1'b1;  // pc+1 wraps naturally
`ifdef SUBNEG_OVF_EN
        ovf_d     = sub_ovf;
`endif
        state_d   = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      pc_q      <= '0;
      tgt_q     <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      next_pc_q <= '0;
`ifdef SUBNEG_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      next_pc_q <= next_pc_d;
`ifdef SUBNEG_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.neg       = neg_q;
  assign bus.next_pc   = next_pc_q;
`ifdef SUBNEG_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule
